pipe_hazard_ctrl: RTL and testbench



---
 rtl/pipe_ctrl_pkg.sv | 23 ++
 rtl/hazard_detect.sv | 20 ++
 rtl/pipe_hazard_ctrl.sv | 149 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing / hazard controller.
// Holds the controller state encoding, instruction-type opcodes and the
// NIC address-space tag used by the decode and memory stages.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    NIC_WAIT = 2'b01,
    FLUSH    = 2'b10
  } ctrl_state_t;

  // Instruction-type constants shared with the decoder
  localparam logic [5:0] OP_R     = 6'b101010;
  localparam logic [5:0] OP_LOAD  = 6'b100000;
  localparam logic [5:0] OP_STORE = 6'b100001;
  localparam logic [5:0] OP_BEQ   = 6'b100010;
  localparam logic [5:0] OP_BNE   = 6'b100011;
  localparam logic [5:0] OP_NOP   = 6'b111000;

  // Upper address bits that select the NIC address space
  localparam logic [1:0] NIC_ADDR_TAG = 2'b11;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard comparator: flags an ID instruction that reads the
// destination of a load currently in EX. Purely combinational, zero latency.
// No flow control of its own; the caller decides how to stall.
module hazard_detect (
  input  logic       ex_load,
  input  logic [0:4] ex_wreg,
  input  logic [0:4] id_reg1,
  input  logic [0:4] id_reg2,
  input  logic       id_use1,
  input  logic       id_use2,
  output logic       hit
);

  // Only sources the decoder marks as really read can create a hazard
  always_comb begin
    hit = ex_load && ((id_use1 && (id_reg1 == ex_wreg)) ||
                      (id_use2 && (id_reg2 == ex_wreg)));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core: load-use bubbles, branch squash, NIC freeze.
// Control outputs are combinational from registered state and current inputs (0 cycles).
// A pending NIC access freezes every stage until nic_ready or the timeout releases it.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NIC_TIMEOUT  = 255,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [0:4]  id_reg1,
  input  logic [0:4]  id_reg2,
  input  logic        id_use1,
  input  logic        id_use2,
  input  logic [0:4]  ex_Wreg,
  input  logic        ex_load,
  input  logic        ex_br_taken,
  input  logic        mem_nic_en,
  input  logic        nic_ready,
  output logic        pc_en,
  output logic        ifid_stall,
  output logic        ifid_flush,
  output logic        idex_stall,
  output logic        idex_flush,
  output logic        pipe_hold,
  output logic        nic_timeout,
  output logic [0:15] stall_cnt
);

  localparam logic [15:0] TMO_LAST  = 16'(NIC_TIMEOUT - 1);
  localparam logic [1:0]  FL_RELOAD = 2'(FLUSH_CYCLES - 1);

  ctrl_state_t state, state_n;
  logic [15:0] timer, timer_n;
  logic [1:0]  fcnt, fcnt_n;
  logic        timeout_set;
  logic        freeze, act_run, act_flush;
  logic        nic_block;
  logic        hit;

  hazard_detect u_hazard_detect (
    .ex_load (ex_load),
    .ex_wreg (ex_Wreg),
    .id_reg1 (id_reg1),
    .id_reg2 (id_reg2),
    .id_use1 (id_use1),
    .id_use2 (id_use2),
    .hit     (hit)
  );

  assign nic_block = mem_nic_en && !nic_ready;

  // Decide this cycle's behaviour, drive controls and compute next state.
  // A NIC release cycle behaves like RUN, or like FLUSH when a flush was interrupted.
  always_comb begin
    state_n     = state;
    timer_n     = timer;
    fcnt_n      = fcnt;
    timeout_set = 1'b0;
    freeze      = 1'b0;
    act_run     = 1'b0;
    act_flush   = 1'b0;
    pc_en       = 1'b1;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_stall  = 1'b0;
    idex_flush  = 1'b0;
    pipe_hold   = 1'b0;

    case (state)
      RUN, FLUSH: begin
        if (nic_block) begin
          freeze  = 1'b1;
          state_n = NIC_WAIT;
          timer_n = '0;
        end else if (state == RUN) begin
          act_run = 1'b1;
        end else begin
          act_flush = 1'b1;
        end
      end
      NIC_WAIT: begin
        if (nic_ready || (timer == TMO_LAST)) begin
          timeout_set = !nic_ready;
          state_n     = RUN;
          timer_n     = '0;
          if (fcnt != 2'd0) act_flush = 1'b1;
          else              act_run   = 1'b1;
        end else begin
          freeze  = 1'b1;
          timer_n = timer + 16'd1;
        end
      end
      default: state_n = RUN;
    endcase

    if (freeze) begin
      pc_en      = 1'b0;
      ifid_stall = 1'b1;
      idex_stall = 1'b1;
      pipe_hold  = 1'b1;
    end else if (act_run) begin
      // A taken branch squashes the consumer, so a coincident hit is ignored
      if (ex_br_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          state_n = FLUSH;
          fcnt_n  = FL_RELOAD;
        end
      end else if (hit) begin
        pc_en      = 1'b0;
        ifid_stall = 1'b1;
        idex_flush = 1'b1;
      end
    end else if (act_flush) begin
      ifid_flush = 1'b1;
      if (ex_br_taken) begin
        idex_flush = 1'b1;
        fcnt_n     = FL_RELOAD;
        state_n    = (FL_RELOAD != 2'd0) ? FLUSH : RUN;
      end else begin
        fcnt_n  = (fcnt == 2'd0) ? 2'd0 : fcnt - 2'd1;
        state_n = (fcnt <= 2'd1) ? RUN : FLUSH;
      end
    end
  end

  // Register controller state, sticky timeout flag and saturating stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      timer       <= '0;
      fcnt        <= '0;
      nic_timeout <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      state       <= state_n;
      timer       <= timer_n;
      fcnt        <= fcnt_n;
      nic_timeout <= nic_timeout | timeout_set;
      if (!pc_en && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl with an expected-output queue.
// Each cycle's expected controls are queued when the inputs are driven and
// popped and compared on the following falling edge.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic [0:4] r1;
    logic [0:4] r2;
    logic       u1;
    logic       u2;
    logic [0:4] wreg;
    logic       ld;
    logic       br;
    logic       nic;
    logic       rdy;
  } stim_t;

  // {pc_en, ifid_stall, ifid_flush, idex_stall, idex_flush, pipe_hold}
  typedef logic [5:0] ctrl_t;

  typedef struct packed {
    ctrl_t       ctrl;
    logic        tmo;
    logic [15:0] cnt;
  } exp_t;

  localparam ctrl_t C_IDLE = 6'b100000;
  localparam ctrl_t C_LU   = 6'b010010;
  localparam ctrl_t C_BR   = 6'b101010;
  localparam ctrl_t C_FL   = 6'b101000;
  localparam ctrl_t C_FRZ  = 6'b010101;

  localparam stim_t S_IDLE   = '{r1:5'd0, r2:5'd0, u1:1'b0, u2:1'b0, wreg:5'd0, ld:1'b0, br:1'b0, nic:1'b0, rdy:1'b0};
  localparam stim_t S_LU     = '{r1:5'd3, r2:5'd5, u1:1'b1, u2:1'b1, wreg:5'd5, ld:1'b1, br:1'b0, nic:1'b0, rdy:1'b0};
  localparam stim_t S_LU_NU  = '{r1:5'd3, r2:5'd5, u1:1'b1, u2:1'b0, wreg:5'd5, ld:1'b1, br:1'b0, nic:1'b0, rdy:1'b0};
  localparam stim_t S_LU_R1  = '{r1:5'd9, r2:5'd1, u1:1'b1, u2:1'b1, wreg:5'd9, ld:1'b1, br:1'b0, nic:1'b0, rdy:1'b0};
  localparam stim_t S_NOLD   = '{r1:5'd9, r2:5'd9, u1:1'b1, u2:1'b1, wreg:5'd9, ld:1'b0, br:1'b0, nic:1'b0, rdy:1'b0};
  localparam stim_t S_BR     = '{r1:5'd0, r2:5'd0, u1:1'b0, u2:1'b0, wreg:5'd0, ld:1'b0, br:1'b1, nic:1'b0, rdy:1'b0};
  localparam stim_t S_BR_LU  = '{r1:5'd3, r2:5'd5, u1:1'b1, u2:1'b1, wreg:5'd5, ld:1'b1, br:1'b1, nic:1'b0, rdy:1'b0};
  localparam stim_t S_NIC_LO = '{r1:5'd0, r2:5'd0, u1:1'b0, u2:1'b0, wreg:5'd0, ld:1'b0, br:1'b0, nic:1'b1, rdy:1'b0};
  localparam stim_t S_NIC_HI = '{r1:5'd0, r2:5'd0, u1:1'b0, u2:1'b0, wreg:5'd0, ld:1'b0, br:1'b0, nic:1'b1, rdy:1'b1};
  localparam stim_t S_NLO_BR = '{r1:5'd0, r2:5'd0, u1:1'b0, u2:1'b0, wreg:5'd0, ld:1'b0, br:1'b1, nic:1'b1, rdy:1'b0};
  localparam stim_t S_NHI_BR = '{r1:5'd0, r2:5'd0, u1:1'b0, u2:1'b0, wreg:5'd0, ld:1'b0, br:1'b1, nic:1'b1, rdy:1'b1};

  logic        clk = 1'b0;
  logic        rst;
  logic [0:4]  id_reg1, id_reg2, ex_Wreg;
  logic        id_use1, id_use2, ex_load, ex_br_taken, mem_nic_en, nic_ready;
  logic        pc_en, ifid_stall, ifid_flush, idex_stall, idex_flush, pipe_hold, nic_timeout;
  logic [0:15] stall_cnt;

  int   vectors    = 0;
  int   miscompares = 0;
  int   stalls     = 0;
  logic tmo_exp    = 1'b0;
  exp_t sb[$];

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.NIC_TIMEOUT(8), .FLUSH_CYCLES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .id_reg1     (id_reg1),
    .id_reg2     (id_reg2),
    .id_use1     (id_use1),
    .id_use2     (id_use2),
    .ex_Wreg     (ex_Wreg),
    .ex_load     (ex_load),
    .ex_br_taken (ex_br_taken),
    .mem_nic_en  (mem_nic_en),
    .nic_ready   (nic_ready),
    .pc_en       (pc_en),
    .ifid_stall  (ifid_stall),
    .ifid_flush  (ifid_flush),
    .idex_stall  (idex_stall),
    .idex_flush  (idex_flush),
    .pipe_hold   (pipe_hold),
    .nic_timeout (nic_timeout),
    .stall_cnt   (stall_cnt)
  );

  function automatic exp_t observe();
    exp_t o;
    o.ctrl = {pc_en, ifid_stall, ifid_flush, idex_stall, idex_flush, pipe_hold};
    o.tmo  = nic_timeout;
    o.cnt  = stall_cnt;
    return o;
  endfunction

  // Drive one cycle of inputs and queue what the controller must show
  task automatic drive(input stim_t s, input ctrl_t c);
    exp_t e;
    id_reg1     = s.r1;
    id_reg2     = s.r2;
    id_use1     = s.u1;
    id_use2     = s.u2;
    ex_Wreg     = s.wreg;
    ex_load     = s.ld;
    ex_br_taken = s.br;
    mem_nic_en  = s.nic;
    nic_ready   = s.rdy;
    e.ctrl = c;
    e.tmo  = tmo_exp;
    e.cnt  = 16'(stalls);
    sb.push_back(e);
  endtask

  task automatic advance(input exp_t want);
    if (!want.ctrl[5]) stalls++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(S_IDLE, C_IDLE);
    sb.delete();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    stalls  = 0;
    tmo_exp = 1'b0;
  endtask

  task automatic test_reset();
    exp_t got, want;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(S_IDLE, C_IDLE);
      @(negedge clk);
      got = observe(); want = sb.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL reset[%0d] got=%h want=%h", i, got, want);
      end
      advance(want);
    end
  endtask

  task automatic test_load_use();
    stim_t s[6] = '{S_LU, S_IDLE, S_LU_NU, S_LU_R1, S_NOLD, S_IDLE};
    ctrl_t c[6] = '{C_LU, C_IDLE, C_IDLE, C_LU, C_IDLE, C_IDLE};
    exp_t got, want;
    for (int i = 0; i < 6; i++) begin
      drive(s[i], c[i]);
      @(negedge clk);
      got = observe(); want = sb.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL load_use[%0d] got=%h want=%h", i, got, want);
      end
      advance(want);
    end
  endtask

  task automatic test_branch();
    stim_t s[6] = '{S_BR, S_IDLE, S_IDLE, S_BR_LU, S_LU, S_IDLE};
    ctrl_t c[6] = '{C_BR, C_FL, C_IDLE, C_BR, C_FL, C_IDLE};
    exp_t got, want;
    for (int i = 0; i < 6; i++) begin
      drive(s[i], c[i]);
      @(negedge clk);
      got = observe(); want = sb.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL branch[%0d] got=%h want=%h", i, got, want);
      end
      advance(want);
    end
  endtask

  task automatic test_back_to_back();
    stim_t s[7] = '{S_BR, S_BR, S_IDLE, S_IDLE, S_LU, S_LU, S_IDLE};
    ctrl_t c[7] = '{C_BR, C_BR, C_FL, C_IDLE, C_LU, C_LU, C_IDLE};
    exp_t got, want;
    for (int i = 0; i < 7; i++) begin
      drive(s[i], c[i]);
      @(negedge clk);
      got = observe(); want = sb.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL back_to_back[%0d] got=%h want=%h", i, got, want);
      end
      advance(want);
    end
  endtask

  task automatic test_nic_wait();
    stim_t s[16] = '{S_NIC_LO, S_NIC_LO, S_NIC_LO, S_NIC_LO, S_NIC_HI, S_IDLE,
                     S_BR, S_NIC_LO, S_NIC_LO, S_NIC_HI, S_IDLE,
                     S_NIC_LO, S_NLO_BR, S_NHI_BR, S_IDLE, S_IDLE};
    ctrl_t c[16] = '{C_FRZ, C_FRZ, C_FRZ, C_FRZ, C_IDLE, C_IDLE,
                     C_BR, C_FRZ, C_FRZ, C_FL, C_IDLE,
                     C_FRZ, C_FRZ, C_BR, C_FL, C_IDLE};
    exp_t got, want;
    for (int i = 0; i < 16; i++) begin
      drive(s[i], c[i]);
      @(negedge clk);
      got = observe(); want = sb.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL nic_wait[%0d] got=%h want=%h", i, got, want);
      end
      advance(want);
    end
  endtask

  task automatic test_timeout();
    exp_t got, want;
    for (int i = 0; i < 11; i++) begin
      if (i < 8)       drive(S_NIC_LO, C_FRZ);
      else if (i == 8) drive(S_NIC_LO, C_IDLE);
      else             drive(S_IDLE, C_IDLE);
      @(negedge clk);
      got = observe(); want = sb.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL timeout[%0d] got=%h want=%h", i, got, want);
      end
      advance(want);
      if (i == 8) tmo_exp = 1'b1;
    end
  endtask

  task automatic test_reset_mid();
    exp_t got, want;
    // Reset while in FLUSH with the timeout flag still set
    drive(S_BR, C_BR);
    @(negedge clk);
    got = observe(); want = sb.pop_front(); vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL reset_mid_flush_pre got=%h want=%h", got, want);
    end
    advance(want);
    do_reset();
    drive(S_IDLE, C_IDLE);
    @(negedge clk);
    got = observe(); want = sb.pop_front(); vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL reset_mid_flush got=%h want=%h", got, want);
    end
    advance(want);
    // Reset while frozen on the NIC
    for (int i = 0; i < 2; i++) begin
      drive(S_NIC_LO, C_FRZ);
      @(negedge clk);
      got = observe(); want = sb.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL reset_mid_nic_pre[%0d] got=%h want=%h", i, got, want);
      end
      advance(want);
    end
    do_reset();
    drive(S_IDLE, C_IDLE);
    @(negedge clk);
    got = observe(); want = sb.pop_front(); vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL reset_mid_nic got=%h want=%h", got, want);
    end
    advance(want);
  endtask

  initial begin
    rst = 1'b1;
    drive(S_IDLE, C_IDLE);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_branch();
    test_back_to_back();
    test_nic_wait();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
